// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter sharing one resource between N requesters.
// One-hot rotating priority pointer, registered grant, and a hold limit that preempts long tenures.
module ring_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 timeout
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [N-1:0]   ptr;
    logic [HW-1:0]  hold_cnt;

    logic [N-1:0]   others;
    logic [N-1:0]   cand;
    logic [N-1:0]   win;
    logic [N-1:0]   win_next_ptr;
    logic [IW-1:0]  win_idx;
    logic           own_done;
    logic           own_req;
    logic           at_limit;
    logic           rel;

    // Scan twice around the ring so the search starts at ptr and wraps N-1 -> 0.
    function automatic logic [N-1:0] pick(input logic [N-1:0] m, input logic [N-1:0] p);
        logic [N-1:0] g;
        logic         seen;
        logic         found;
        g     = '0;
        seen  = 1'b0;
        found = 1'b0;
        for (int unsigned k = 0; k < 2 * N; k++) begin
            if (p[k % N])
                seen = 1'b1;
            if (seen && !found && m[k % N]) begin
                g[k % N] = 1'b1;
                found    = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [IW-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IW-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (oh[i])
                idx = idx | IW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        others       = req & ~grant;
        cand         = (state == IDLE) ? req : others;
        win          = pick(cand, ptr);
        win_next_ptr = {win[N-2:0], win[N-1]};
        win_idx      = onehot_to_idx(win);
        own_done     = |(done & grant);
        own_req      = |(req & grant);
        at_limit     = (hold_cnt == HW'(MAX_HOLD));
        rel          = own_done | ~own_req | at_limit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner_id <= '0;
            timeout  <= 1'b0;
            ptr      <= N'(1);
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        grant    <= win;
                        owner_id <= win_idx;
                        hold_cnt <= HW'(1);
                        ptr      <= win_next_ptr;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!rel) begin
                        hold_cnt <= hold_cnt + HW'(1);
                        timeout  <= 1'b0;
                    end else begin
                        // Only a pure hold-limit release, with the owner still asking, flags a timeout.
                        timeout <= at_limit & ~own_done & own_req;
                        if (|others) begin
                            grant    <= win;
                            owner_id <= win_idx;
                            hold_cnt <= HW'(1);
                            ptr      <= win_next_ptr;
                        end else begin
                            grant    <= '0;
                            owner_id <= '0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    owner_id <= '0;
                    timeout  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed and randomised checks of ring_rr_arbiter against an integer-level arbitration model
// plus a fairness/tenure scoreboard.
module tb_ring_rr_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] grant;
    logic [1:0]   owner_id;
    logic         timeout;

    ring_rr_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .owner_id(owner_id), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: owner index (-1 = none), index where the next search starts, tenure length.
    int m_owner = -1;
    int m_start = 0;
    int m_hold  = 0;
    bit m_to    = 0;

    // Scoreboard state.
    logic [N-1:0] prev_grant = '0;
    int           tenure = 0;
    int           waits[N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] m, input int start);
        for (int k = 0; k < N; k++)
            if (m[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic award(input int w);
        m_owner = w;
        m_hold  = 1;
        m_start = (w + 1) % N;
    endtask

    task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        logic [N-1:0] oth;
        bit lim, rel;
        if (r) begin
            m_owner = -1; m_start = 0; m_hold = 0; m_to = 0;
        end else if (m_owner < 0) begin
            m_to = 0;
            if (rq != 0) award(first_from(rq, m_start));
        end else begin
            lim = (m_hold == MAXH);
            rel = dn[m_owner] || !rq[m_owner] || lim;
            if (!rel) begin
                m_hold++;
                m_to = 0;
            end else begin
                m_to = lim && !dn[m_owner] && rq[m_owner];
                oth = rq;
                oth[m_owner] = 1'b0;
                if (oth != 0) award(first_from(oth, m_start));
                else m_owner = -1;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic scoreboard(input logic [N-1:0] rq_at_edge);
        int w;
        check("onehot0", {31'b0, $onehot0(grant)}, 32'd1);
        if (grant == '0) tenure = 0;
        else if (grant == prev_grant) tenure++;
        else tenure = 1;
        check("tenure_le_max", {31'b0, tenure <= MAXH}, 32'd1);
        if (grant != '0 && grant != prev_grant) begin
            w = -1;
            for (int i = 0; i < N; i++) if (grant[i]) w = i;
            for (int i = 0; i < N; i++) begin
                if (i == w || !rq_at_edge[i]) waits[i] = 0;
                else waits[i]++;
                check($sformatf("wait_le_n[%0d]", i), {31'b0, waits[i] <= N}, 32'd1);
            end
        end
        for (int i = 0; i < N; i++) if (!rq_at_edge[i]) waits[i] = 0;
        prev_grant = grant;
    endtask

    task automatic cycle(input bit r, input logic [N-1:0] rq, input logic [N-1:0] dn);
        rst = r; req = rq; done = dn;
        model_step(r, rq, dn);
        @(posedge clk);
        #1;
        check("grant", {28'b0, grant}, {28'b0, exp_grant()});
        check("owner_id", {30'b0, owner_id}, (m_owner < 0) ? 32'd0 : m_owner);
        check("timeout", {31'b0, timeout}, {31'b0, m_to});
        scoreboard(r ? '0 : rq);
    endtask

    logic [N-1:0] rq_r, dn_r;
    int n_hold;

    initial begin
        for (int i = 0; i < N; i++) waits[i] = 0;

        // 1: reset state, first grant, back-to-back handoff
        cycle(1, '0, '0);
        check("rst_grant", {28'b0, grant}, 32'h0);
        check("rst_timeout", {31'b0, timeout}, 32'h0);
        cycle(0, 4'b0101, '0);
        check("t1_first", {28'b0, grant}, 32'h1);
        check("t1_owner", {30'b0, owner_id}, 32'd0);
        cycle(0, 4'b0101, 4'b0001);
        check("t1_handoff", {28'b0, grant}, 32'h4);
        cycle(0, '0, '0);

        // 2: full rotation with done each grant
        cycle(1, '0, '0);
        cycle(0, 4'b1111, '0);
        check("t2_g0", {28'b0, grant}, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            cycle(0, 4'b1111, grant);
            check($sformatf("t2_g%0d", k), {28'b0, grant}, 32'h1 << (k % 4));
            check("t2_no_to", {31'b0, timeout}, 32'h0);
        end
        cycle(0, '0, '0);

        // 3: hold limit preemption, one idle cycle, re-grant
        cycle(1, '0, '0);
        cycle(0, 4'b0010, '0);
        n_hold = 1;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 4'b0010, '0);
            if (grant == 4'b0010) n_hold++;
            else break;
        end
        check("t3_tenure", n_hold, MAXH);
        check("t3_timeout", {31'b0, timeout}, 32'h1);
        check("t3_idle", {28'b0, grant}, 32'h0);
        cycle(0, 4'b0010, '0);
        check("t3_regrant", {28'b0, grant}, 32'h2);
        check("t3_to_clear", {31'b0, timeout}, 32'h0);
        cycle(0, '0, '0);

        // 4: non-owner done ignored, owner drops req without done
        cycle(1, '0, '0);
        cycle(0, 4'b0100, '0);
        cycle(0, 4'b0100, 4'b0010);
        check("t4_done_nonowner", {28'b0, grant}, 32'h4);
        cycle(0, 4'b0000, '0);
        check("t4_drop", {28'b0, grant}, 32'h0);
        check("t4_drop_to", {31'b0, timeout}, 32'h0);
        cycle(0, '0, 4'b1111);
        check("t4_idle_done", {28'b0, grant}, 32'h0);

        // 5: reset mid-tenure restores pointer
        cycle(1, '0, '0);
        cycle(0, 4'b0100, '0);
        cycle(0, 4'b0100, '0);
        cycle(0, 4'b0100, '0);
        cycle(1, 4'b0100, '0);
        check("t5_rst", {28'b0, grant}, 32'h0);
        cycle(0, 4'b1100, '0);
        check("t5_ptr", {28'b0, grant}, 32'h4);
        cycle(0, '0, '0);

        // 6: randomised traffic; requests held until the requester has owned the resource
        rq_r = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq_r[i]) begin
                    if (m_owner == i && $urandom_range(3) == 0) rq_r[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    rq_r[i] = 1'b1;
                end
            end
            dn_r = '0;
            for (int i = 0; i < N; i++) begin
                if (m_owner == i) dn_r[i] = ($urandom_range(4) == 0);
                else dn_r[i] = ($urandom_range(7) == 0);
            end
            if ($urandom_range(499) == 0) begin
                cycle(1, rq_r, dn_r);
            end else begin
                cycle(0, rq_r, dn_r);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
